multihat_grng: RTL and testbench

//  Parametrised multi-hat Gaussian RNG; successor to the fixed 4-channel generator.
//  N_HATS independent 32-bit Galois LFSRs each feed a triangular "hat" stage.
//  A pipelined adder tree sums the hats (CLT), then the sum is scaled and saturated.

---
 rtl/grng_pkg.sv | 19 +
 rtl/grng_lfsr32.sv | 26 ++
 rtl/multihat_grng.sv | 145 ++++++++++++++
 tb/tb_multihat_grng.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grng_pkg.sv
// rtl/grng_pkg.sv - shared constants, types and helpers for the multi-hat Gaussian RNG
package grng_pkg;

  localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED_BASE = 32'hACE1_0000;
  localparam logic [31:0] ZERO_SEED_SUB     = 32'hACE1_ACE1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef logic signed [16:0] hat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/grng_lfsr32.sv
// rtl/grng_lfsr32.sv - 32-bit right-shift Galois LFSR with seed load and advance enable
module grng_lfsr32
  import grng_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = DEFAULT_SEED_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] value
);

  // An all-zero state would lock the register up, so a zero seed is substituted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= RESET_SEED;
    end else if (load) begin
      value <= (seed == '0) ? ZERO_SEED_SUB : seed;
    end else if (adv) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
    end
  end

endmodule

// File: rtl/multihat_grng.sv
// rtl/multihat_grng.sv - multi-hat CLT Gaussian RNG: LFSRs, hats, adder tree, saturation, burst FSM
module multihat_grng
  import grng_pkg::*;
#(
  parameter  int N_HATS  = 4,
  parameter  int OUT_W   = 16,
  parameter  int SHIFT   = 1,
  parameter  int BURST_W = 16,
  localparam int LG      = clog2(N_HATS),
  localparam int IDX_W   = (LG > 0) ? LG : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_we,
  input  logic [IDX_W-1:0]   seed_idx,
  input  logic [31:0]        seed_data,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               stop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  localparam int SUM_W = 17 + LG;
  localparam int EW    = (SUM_W > OUT_W) ? SUM_W : OUT_W;
  localparam int NV    = LG + 2;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                  state;
  logic [BURST_W-1:0]      cnt;
  logic [BURST_W-1:0]      len_q;
  logic [BURST_W-1:0]      cnt_inc;
  logic [NV-1:0]           pipe_v;
  logic [31:0]             lfsr_q [N_HATS];
  hat_t                    hat_q  [N_HATS];
  logic signed [SUM_W-1:0] sum_q  [1:N_HATS-1];
  logic signed [SUM_W-1:0] node   [1:2*N_HATS-1];
  logic signed [EW-1:0]    scaled;
  logic [OUT_W-1:0]        sat_out;
  logic                    running;
  logic                    adv;
  logic                    xfer;
  logic                    seed_ok;
  logic                    last_xfer;

  assign running   = (state == RUN);
  assign busy      = running;
  assign xfer      = out_valid & out_ready;
  assign adv       = running & (~out_valid | out_ready);
  assign seed_ok   = seed_we & ~busy;
  assign cnt_inc   = cnt + BURST_W'(1);
  assign last_xfer = xfer & (len_q != '0) & (cnt_inc == len_q);

  for (genvar g = 0; g < N_HATS; g++) begin : gen_lfsr
    grng_lfsr32 #(
      .RESET_SEED(DEFAULT_SEED_BASE + 32'(g))
    ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (seed_ok & (seed_idx == IDX_W'(g))),
      .seed  (seed_data),
      .adv   (adv),
      .value (lfsr_q[g])
    );
  end

  // Heap-ordered tree: node k sums children 2k and 2k+1; leaves N..2N-1 are the hats.
  always_comb begin
    for (int k = 1; k < N_HATS; k++) node[k] = sum_q[k];
    for (int i = 0; i < N_HATS; i++) node[N_HATS + i] = SUM_W'(hat_q[i]);
  end

  always_comb begin
    scaled = EW'(node[1] >>> SHIFT);
    if (scaled > SAT_MAX) begin
      sat_out = SAT_MAX[OUT_W-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_out = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_out = scaled[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_HATS; i++) hat_q[i] <= '0;
      for (int k = 1; k < N_HATS; k++) sum_q[k] <= '0;
      out_data <= '0;
    end else if (adv) begin
      for (int i = 0; i < N_HATS; i++) begin
        hat_q[i] <= $signed({1'b0, lfsr_q[i][31:16]}) - $signed({1'b0, lfsr_q[i][15:0]});
      end
      for (int k = 1; k < N_HATS; k++) sum_q[k] <= node[2*k] + node[2*k+1];
      out_data <= sat_out;
    end
  end

  // Ending a run clears every valid bit, so in-flight samples are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      pipe_v    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      pipe_v    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            len_q     <= burst_len;
            pipe_v    <= '0;
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (last_xfer) begin
            state     <= IDLE;
            done      <= 1'b1;
            pipe_v    <= '0;
            out_valid <= 1'b0;
          end else if (adv) begin
            pipe_v    <= {pipe_v[NV-2:0], 1'b1};
            out_valid <= pipe_v[NV-1];
            if (xfer) cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multihat_grng.sv
// tb/tb_multihat_grng.sv - directed self-checking bench for multihat_grng
module tb_multihat_grng;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        seed_we = 1'b0;
  logic [1:0]  seed_idx = '0;
  logic [31:0] seed_data = '0;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        stop = 1'b0;
  logic        out_ready = 1'b0;
  logic        v0, v1, busy0, busy1, done0, done1;
  logic [15:0] d0;
  logic [11:0] d1;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_lfsr [N];
  int exp0 [0:127];
  int exp1 [0:127];

  always #5 clk = ~clk;

  multihat_grng #(.N_HATS(4), .OUT_W(16), .SHIFT(1), .BURST_W(16)) dut_a (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed_idx(seed_idx), .seed_data(seed_data),
    .start(start), .burst_len(burst_len), .stop(stop), .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .busy(busy0), .done(done0)
  );

  multihat_grng #(.N_HATS(4), .OUT_W(12), .SHIFT(0), .BURST_W(16)) dut_b (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed_idx(seed_idx), .seed_data(seed_data),
    .start(start), .burst_len(burst_len), .stop(stop), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic int model_out(input int shift, input int out_w);
    int sum, y, hi, lo;
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(m_lfsr[i][31:16]) - int'(m_lfsr[i][15:0]);
    y  = sum >>> shift;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  task automatic model_skip(input int n);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < N; i++) m_lfsr[i] = lfsr_step(m_lfsr[i]);
  endtask

  task automatic gen_expected(input int n);
    for (int k = 0; k < n; k++) begin
      model_skip(1);
      exp0[k] = model_out(1, 16);
      exp1[k] = model_out(0, 12);
    end
  endtask

  task automatic seed_one(input int idx, input logic [31:0] val);
    seed_we   = 1'b1;
    seed_idx  = 2'(idx);
    seed_data = val;
    tick();
    seed_we   = 1'b0;
    m_lfsr[idx] = (val == 32'h0) ? 32'hACE1_ACE1 : val;
  endtask

  task automatic collect(input string tag, input int n, input int stall_at);
    int k, dn, stall;
    k = 0; dn = 0; stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done0) begin
        dn++;
        check({tag, " done at last"}, k, n);
      end
      if (k == n && !busy0) break;
      check({tag, " valid b"}, v1, v0);
      if (stall > 0 && k == stall_at) check({tag, " stall valid"}, v0, 1);
      if (v0) begin
        check({tag, " data a"}, $signed(d0), exp0[k]);
        check({tag, " data b"}, $signed(d1), exp1[k]);
      end
      out_ready = !(k == stall_at && v0 && stall < 5);
      if (!out_ready) stall++;
      if (v0 && out_ready) k++;
      tick();
    end
    check({tag, " transfers"}, k, n);
    check({tag, " done pulses"}, dn, 1);
    check({tag, " busy after"}, busy0, 0);
    check({tag, " valid after"}, v0, 0);
    out_ready = 1'b1;
    tick();
    check({tag, " done one cycle"}, done0, 0);
  endtask

  initial begin
    int lat, k, sats_dut, sats_exp;

    repeat (3) tick();
    check("rst out_valid", v0, 0);
    check("rst out_data", d0, 0);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    reset = 1'b1;
    tick();
    check("post-rst out_valid", v0, 0);
    check("post-rst out_data", d0, 0);
    check("post-rst busy", busy0, 0);
    check("post-rst done", done0, 0);

    // Seed channel 0 only; others keep their reset seeds.
    out_ready = 1'b1;
    burst_len = 16'd10;
    seed_one(0, 32'h0000_0001);
    m_lfsr = '{32'h0000_0001, 32'hACE1_0001, 32'hACE1_0002, 32'hACE1_0003};
    gen_expected(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy after start", busy0, 1);
    lat = 0;
    while (!v0 && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) check("lfsr0 first adv", dut_a.lfsr_q[0], 32'h8020_0003);
      if (lat == 2) check("hat0", dut_a.hat_q[0], 17'h0801D);
    end
    check("latency", lat, 5);
    collect("burst10", 10, -1);

    // LFSRs persist: 10 transfers plus 5 in-flight advances were consumed.
    model_skip(5);
    gen_expected(3);
    burst_len = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect("burst3", 3, -1);

    model_skip(5);
    seed_one(0, 32'hDEAD_BEEF);
    seed_one(1, 32'h0F0F_1234);
    seed_one(2, 32'h0000_0000);
    check("zero seed sub", dut_a.lfsr_q[2], 32'hACE1_ACE1);
    m_lfsr[3] = 32'h8000_0001;
    gen_expected(20);
    burst_len = 16'd20;
    seed_we   = 1'b1;
    seed_idx  = 2'd3;
    seed_data = 32'h8000_0001;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    seed_idx  = 2'd0;
    seed_data = 32'h5555_5555;
    tick();
    seed_we   = 1'b0;
    collect("stall", 20, 5);

    model_skip(5);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start+stop idle busy", busy0, 0);

    burst_len = 16'd0;
    gen_expected(110);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; sats_dut = 0; sats_exp = 0;
    for (int cyc = 0; cyc < 1000 && k < 100; cyc++) begin
      check("cont no done", done0, 0);
      if (v0) begin
        check("cont data a", $signed(d0), exp0[k]);
        check("cont data b", $signed(d1), exp1[k]);
        if (d1 == 12'h7FF || d1 == 12'h800) sats_dut++;
        if (exp1[k] == 2047 || exp1[k] == -2048) sats_exp++;
      end
      out_ready = (cyc % 5 != 2);
      if (v0 && out_ready) k++;
      tick();
    end
    check("cont transfers", k, 100);
    check("cont saturations", sats_dut, sats_exp);
    check("cont still busy", busy0, 1);
    stop = 1'b1;
    out_ready = 1'b0;
    tick();
    stop = 1'b0;
    check("stop busy", busy0, 0);
    check("stop valid", v0, 0);
    check("stop done", done0, 0);
    tick();
    check("stop done later", done0, 0);
    check("stop busy later", busy0, 0);

    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre-reset valid", v0, 1);
    reset = 1'b0;
    #2;
    check("async rst valid", v0, 0);
    check("async rst busy", busy0, 0);
    check("async rst data", d0, 0);
    check("async rst lfsr1", dut_a.lfsr_q[1], 32'hACE1_0001);
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
